// File: rtl/cover_toggle_pkg.sv
// cover_toggle_pkg: shared sizing constants, collector state enum and masked group extract
package cover_toggle_pkg;
    localparam int COVER_TOTAL = 8940;
    localparam int GROUP_W = 8;
    localparam int WORD_W = 32;
    localparam int IDX_W = 14;
    localparam int NUM_WORDS = (COVER_TOTAL + WORD_W - 1) / WORD_W;
    localparam int ADDR_W = $clog2(NUM_WORDS);
    localparam int MAP_W = NUM_WORDS * WORD_W;
    typedef enum logic [1:0] {RUN, CLEAR, DUMP} state_t;
    // Lanes whose global index falls past the last cover point never reach the bitmap.
    function automatic logic [GROUP_W-1:0] group_mask(input logic [IDX_W-1:0] idx, input logic [GROUP_W-1:0] bits);
        logic [GROUP_W-1:0] m;
        for (int i = 0; i < GROUP_W; i++)
            m[i] = bits[i] && (int'(idx) + i < COVER_TOTAL);
        return m;
    endfunction
endpackage

// File: rtl/cover_popcount.sv
// cover_popcount: combinational population count of a W-bit vector
module cover_popcount #(
    parameter int W = 8,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  bits,
    output logic [CW-1:0] count
);
    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++)
            count = count + CW'(bits[i]);
    end
endmodule

// File: rtl/cover_toggle_collector.sv
// cover_toggle_collector: sticky toggle-coverage bitmap with hit/drop counters, sweep clear and word readout
module cover_toggle_collector
    import cover_toggle_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [IDX_W-1:0]    in_index,
    input  logic [GROUP_W-1:0]  in_bits,
    input  logic                clear_req,
    input  logic                dump_start,
    output logic                busy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WORD_W-1:0]   out_data,
    output logic [ADDR_W-1:0]   out_addr,
    output logic                out_last,
    output logic [IDX_W-1:0]    hit_count,
    output logic [15:0]         drop_count
);
    state_t state, state_nx;
    logic [ADDR_W-1:0] ptr, ld_ptr;
    logic [MAP_W-1:0] bitmap;
    logic s1_valid;
    logic [IDX_W-1:0] s1_index;
    logic [GROUP_W-1:0] s1_bits, cur, new_bits;
    logic [$clog2(GROUP_W+1)-1:0] pop;
    logic ptr_last, accept, go_clear, go_dump, load;

    cover_popcount #(.W(GROUP_W)) u_pop (.bits(new_bits), .count(pop));

    // Stage 2 reads the live bitmap flops, so adjacent or overlapping groups need no forwarding.
    always_comb begin
        cur = '0;
        for (int i = 0; i < GROUP_W; i++)
            cur[i] = bitmap[IDX_W'(int'(s1_index) + i)];
        new_bits = group_mask(s1_index, s1_bits) & ~cur;
    end

    assign ptr_last = ptr == ADDR_W'(NUM_WORDS - 1);
    assign accept   = out_valid && out_ready;
    assign go_clear = state == RUN && clear_req;
    assign go_dump  = state == RUN && dump_start && !clear_req;
    assign load     = go_dump || (state == DUMP && accept && !ptr_last);
    assign ld_ptr   = ptr + ADDR_W'(state == DUMP);
    assign busy     = state != RUN;

    always_comb begin
        state_nx = (state == RUN)   ? (clear_req ? CLEAR : dump_start ? DUMP : RUN) :
                   (state == CLEAR) ? (ptr_last ? RUN : CLEAR) :
                   (state == DUMP)  ? ((accept && ptr_last) ? RUN : DUMP) : RUN;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= RUN;
            s1_valid   <= 1'b0;
            s1_index   <= '0;
            s1_bits    <= '0;
            ptr        <= '0;
            bitmap     <= '0;
            hit_count  <= '0;
            drop_count <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_addr   <= '0;
            out_last   <= 1'b0;
        end else begin
            state    <= state_nx;
            s1_valid <= in_valid;
            s1_index <= in_index;
            s1_bits  <= in_bits;
            ptr      <= (state == RUN) ? '0 : (state == CLEAR || accept) ? ptr + 1'b1 : ptr;
            if (state == CLEAR)
                bitmap[IDX_W'(ptr * WORD_W) +: WORD_W] <= '0;
            else if (s1_valid)
                for (int i = 0; i < GROUP_W; i++)
                    if (new_bits[i]) bitmap[IDX_W'(int'(s1_index) + i)] <= 1'b1;
            hit_count  <= go_clear ? '0 : (s1_valid && state != CLEAR) ? hit_count + IDX_W'(pop) : hit_count;
            drop_count <= go_clear ? '0 : (s1_valid && state == CLEAR && drop_count != 16'hFFFF) ? drop_count + 16'd1 : drop_count;
            if (load) begin
                out_valid <= 1'b1;
                out_addr  <= ld_ptr;
                out_last  <= ld_ptr == ADDR_W'(NUM_WORDS - 1);
                out_data  <= bitmap[IDX_W'(ld_ptr * WORD_W) +: WORD_W];
            end else if (accept) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cover_toggle_collector.sv
// tb_cover_toggle_collector: directed plus randomized checks against a bit-array coverage model
module tb_cover_toggle_collector;
    import cover_toggle_pkg::*;
    localparam int M_RUN = 0, M_CLEAR = 1, M_DUMP = 2;

    logic clock = 0, reset = 0, in_valid = 0, clear_req = 0, dump_start = 0, out_ready = 0;
    logic [IDX_W-1:0] in_index = '0;
    logic [GROUP_W-1:0] in_bits = '0;
    logic busy, out_valid, out_last;
    logic [WORD_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic [IDX_W-1:0] hit_count;
    logic [15:0] drop_count;
    int n_cmp = 0, n_fail = 0, ready_mode = 0;

    cover_toggle_collector dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_index(in_index), .in_bits(in_bits),
        .clear_req(clear_req), .dump_start(dump_start), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr), .out_last(out_last),
        .hit_count(hit_count), .drop_count(drop_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 50) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: one bit per cover point plus a coarse mode/word-pointer view of the collector.
    bit mmap [COVER_TOTAL];
    int mset, mmode, mptr, pidx, moa, mdrop;
    bit pv, mov, mol;
    logic [GROUP_W-1:0] pb;
    logic [WORD_W-1:0] mod;

    function automatic logic [WORD_W-1:0] mword(input int w);
        logic [WORD_W-1:0] r;
        r = '0;
        for (int j = 0; j < WORD_W; j++)
            if (w * WORD_W + j < COVER_TOTAL) r[j] = mmap[w * WORD_W + j];
        return r;
    endfunction

    task automatic mload(input int w);
        mov = 1; moa = w; mol = (w == NUM_WORDS - 1); mod = mword(w);
    endtask

    task automatic model_step();
        int nmode, nptr, k;
        bit acc;
        if (!reset) begin
            foreach (mmap[j]) mmap[j] = 0;
            mset = 0; mmode = M_RUN; mptr = 0; pv = 0; pidx = 0; pb = '0;
            mov = 0; mod = '0; moa = 0; mol = 0; mdrop = 0;
            return;
        end
        acc = mov && out_ready;
        nmode = mmode; nptr = mptr;
        if (mmode == M_RUN) begin
            if (clear_req) begin nmode = M_CLEAR; nptr = 0; mdrop = 0; end
            else if (dump_start) begin nmode = M_DUMP; nptr = 0; mload(0); end
        end else if (mmode == M_CLEAR) begin
            nptr = mptr + 1;
            if (mptr == NUM_WORDS - 1) nmode = M_RUN;
        end else if (acc) begin
            if (mptr == NUM_WORDS - 1) begin nmode = M_RUN; mov = 0; end
            else begin nptr = mptr + 1; mload(nptr); end
        end
        if (pv && mmode == M_CLEAR) mdrop = (mdrop == 65535) ? 65535 : mdrop + 1;
        else if (pv)
            for (int i = 0; i < GROUP_W; i++)
                if (pb[i] && pidx + i < COVER_TOTAL && !mmap[pidx + i]) begin mmap[pidx + i] = 1; mset++; end
        if (mmode == M_CLEAR)
            for (int j = 0; j < WORD_W; j++) begin
                k = mptr * WORD_W + j;
                if (k < COVER_TOTAL && mmap[k]) begin mmap[k] = 0; mset--; end
            end
        mmode = nmode; mptr = nptr;
        pv = in_valid; pidx = int'(in_index); pb = in_bits;
    endtask

    // Readout observations taken from the DUT's held outputs at each handshake.
    int hs_cnt, nz_cnt, last_cnt, first_addr, last_addr, exp_next, order_err;
    logic p_ov, p_ol;
    logic [WORD_W-1:0] p_od;
    logic [ADDR_W-1:0] p_oa;

    task automatic clr_cnts();
        hs_cnt = 0; nz_cnt = 0; last_cnt = 0; first_addr = -1; last_addr = -1; exp_next = 0; order_err = 0;
    endtask

    initial begin
        clr_cnts();
        p_ov = 0; p_ol = 0; p_od = '0; p_oa = '0;
        forever begin
            @(posedge clock);
            #1;
            if (p_ov && out_ready && reset) begin
                hs_cnt++;
                if (p_od != 0) nz_cnt++;
                if (p_ol) last_cnt++;
                if (hs_cnt == 1) first_addr = int'(p_oa);
                if (int'(p_oa) != exp_next) order_err++;
                exp_next = int'(p_oa) + 1;
                last_addr = int'(p_oa);
            end
            model_step();
            chk("busy", busy, mmode != M_RUN);
            chk("out_valid", out_valid, mov);
            chk("out_data", out_data, mod);
            chk("out_addr", out_addr, moa);
            chk("out_last", out_last, mol);
            chk("hit_count", hit_count, (mmode == M_CLEAR) ? 0 : mset);
            chk("drop_count", drop_count, mdrop);
            p_ov = out_valid; p_ol = out_last; p_od = out_data; p_oa = out_addr;
        end
    end

    task automatic drv(input bit v, input int idx, input int bits, input bit clr, input bit dmp);
        @(negedge clock);
        in_valid = v; in_index = IDX_W'(idx); in_bits = GROUP_W'(bits);
        clear_req = clr; dump_start = dmp;
        out_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? ~out_ready : 1'($urandom % 2);
    endtask

    task automatic drv0();
        drv(0, 0, 0, 0, 0);
    endtask

    task automatic run_until_idle(input int limit, input bit events);
        int k;
        k = 0;
        drv0();
        while (busy && k < limit) begin
            drv(events && ($urandom % 4 == 0), $urandom_range(0, COVER_TOTAL + 8), $urandom, 0, 0);
            k++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    initial begin
        int k;
        repeat (3) @(negedge clock);
        reset = 1;
        chk("rst_hit", hit_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);

        drv(1, 0, 'h05, 0, 0);
        drv0();
        chk("t1_latency", hit_count, 0);
        drv0();
        chk("t1_hit", hit_count, 2);
        drv(1, 0, 'h05, 0, 0);
        drv0(); drv0();
        chk("t1_repeat", hit_count, 2);

        drv(1, 30, 'hFF, 0, 0);
        drv0(); drv0();
        chk("t2_straddle", hit_count, 10);
        chk("t2_model", mset, 10);
        drv(1, 8936, 'hFF, 0, 0);
        drv0(); drv0();
        chk("t2_upper", hit_count, 14);

        drv(1, 100, 'h0F, 0, 0);
        drv(1, 102, 'h0F, 0, 0);
        drv0(); drv0();
        chk("t3_b2b", hit_count, 20);
        chk("t3_model", mset, 20);

        ready_mode = 1;
        clr_cnts();
        drv(0, 0, 0, 0, 1);
        run_until_idle(2000, 1);
        chk("t4_words", hs_cnt, NUM_WORDS);
        chk("t4_last_addr", last_addr, NUM_WORDS - 1);
        chk("t4_last_cnt", last_cnt, 1);
        chk("t4_order", order_err, 0);
        chk("t4_first_addr", first_addr, 0);

        ready_mode = 0;
        clr_cnts();
        drv(0, 0, 0, 1, 1);
        drv0();
        chk("t5_busy", busy, 1);
        chk("t5_no_valid", out_valid, 0);
        drv0(); drv0();
        for (int i = 0; i < 3; i++) drv(1, 200 + 8 * i, 'hFF, 0, 0);
        run_until_idle(1000, 0);
        chk("t5_drop", drop_count, 3);
        chk("t5_hit", hit_count, 0);
        chk("t5_no_words", hs_cnt, 0);
        drv(0, 0, 0, 0, 1);
        run_until_idle(1000, 0);
        chk("t5_words", hs_cnt, NUM_WORDS);
        chk("t5_zero", nz_cnt, 0);

        drv(1, 40, 'hA5, 0, 0);
        drv(1, 5000, 'h3C, 0, 0);
        drv0(); drv0();
        ready_mode = 2;
        clr_cnts();
        drv(0, 0, 0, 0, 1);
        k = 0;
        while (!(out_valid && out_addr == 57) && k < 2000) begin drv0(); k++; end
        chk("t6_reach", out_addr, 57);
        #2 reset = 0;
        #1;
        chk("t6_valid", out_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_hit", hit_count, 0);
        @(negedge clock);
        reset = 1;
        ready_mode = 0;
        clr_cnts();
        drv(0, 0, 0, 0, 1);
        run_until_idle(1000, 0);
        chk("t6_first_addr", first_addr, 0);
        chk("t6_words", hs_cnt, NUM_WORDS);
        chk("t6_zero", nz_cnt, 0);

        ready_mode = 2;
        repeat (1500)
            drv($urandom % 2, ($urandom % 8 == 0) ? $urandom_range(0, 16383) : $urandom_range(0, COVER_TOTAL),
                $urandom, $urandom % 200 == 0, $urandom % 50 == 0);
        run_until_idle(2000, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
